l2_read_arbiter: RTL and testbench
==================================

L2_READ_ARBITER -- requirements
Module: l2_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, the word-address width (byte address bits [31:2]).
REQ-002 SHALL have parameter W, default 7; the L2 bus width is 2^W bits (128).
REQ-003 SHALL have parameter B, default 9; the block size is 2^B bits; beats per burst L2_BURST = 2^(B-W) (4).
REQ-004 SHALL have port CLK  in  1  system clock, rising-edge; the only clock.
REQ-005 SHALL have port RSTN  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port INS_ADDR  in  ADDR_WIDTH  instruction-cache read address.
REQ-007 SHALL have ports INS_ADDR_VALID in 1 and INS_ADDR_READY out 1, the instruction address handshake.
REQ-008 SHALL have port INS_DATA  out  2^W  read data to the instruction cache.
REQ-009 SHALL have ports INS_DATA_VALID out 1 and INS_DATA_READY in 1, the instruction data handshake.
REQ-010 SHALL have ports DAT_ADDR, DAT_ADDR_VALID, DAT_ADDR_READY, DAT_DATA, DAT_DATA_VALID and DAT_DATA_READY for the data cache, with the same directions and widths as the INS_ ports.
REQ-011 SHALL have ports L2_ADDR out ADDR_WIDTH, L2_ADDR_VALID out 1 and L2_ADDR_READY in 1, the shared L2 read-address channel.
REQ-012 SHALL have ports L2_DATA in 2^W, L2_DATA_VALID in 1 and L2_DATA_READY out 1, the shared L2 read-data channel.
REQ-013 SHALL have port PROTO_ERR  out  1  sticky flag for an unsolicited L2 data beat.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR and DATA, with at most one outstanding L2 read.
REQ-015 IDLE: the grant goes to the single valid requester; if both INS and DAT are valid, it goes to the one not granted last (round-robin, register LAST).
REQ-016 IDLE: the granted requester's ADDR_READY SHALL be 1 combinationally and the other requester's 0; on that handshake the address and owner SHALL be latched, LAST updated, and the FSM SHALL move to ADDR.
REQ-017 SHALL hold both ADDR_READY signals at 0 in ADDR and DATA.
REQ-018 ADDR: L2_ADDR_VALID = 1 and L2_ADDR = latched address, held stable until L2_ADDR_READY; the handshake cycle moves the FSM to DATA.
REQ-019 SHALL make L2_ADDR_VALID first high the cycle after the requester handshake (1-cycle latency).
REQ-020 DATA: owner DATA_VALID = L2_DATA_VALID, owner DATA = L2_DATA, L2_DATA_READY = owner DATA_READY, all combinational (zero latency).
REQ-021 SHALL hold the non-owner's DATA_VALID at 0 and its DATA at 0.
REQ-022 SHALL count beats in a log2(L2_BURST)+1-bit counter on each L2_DATA_VALID&&L2_DATA_READY; the beat that reaches count L2_BURST returns the FSM to IDLE and clears the counter.
REQ-023 SHALL allow a new grant in the cycle after the final beat, never in the same cycle.
REQ-024 Backpressure: owner DATA_READY = 0 stalls the counter and the FSM.
REQ-025 SHALL make L2_DATA_READY 0 outside DATA.
REQ-026 SHALL ignore L2_DATA_VALID outside DATA (no routing, no count) and set PROTO_ERR, which stays 1 until reset.
REQ-027 SHALL not let a requester drop ADDR_VALID before its handshake alter the grant taken on an earlier cycle, since the grant is decided only on the handshake cycle.

Reset
REQ-028 RSTN low SHALL asynchronously force: FSM IDLE, counter 0, LAST = DAT (INS wins the first tie), latched address 0, owner INS, PROTO_ERR 0.
REQ-029 During reset all outputs SHALL be 0: *_ADDR_READY, *_DATA_VALID, *_DATA, L2_ADDR, L2_ADDR_VALID, L2_DATA_READY, PROTO_ERR.
REQ-030 Reset mid-burst SHALL abandon the transaction; any remaining L2 beats after release SHALL be treated as unsolicited (REQ-026).
REQ-031 SHALL sample state on the first rising CLK edge after RSTN deasserts.

Verification
REQ-032 Single INS read: INS_ADDR=0x100, L2 ready, 4 beats 0xA..0xD -> L2_ADDR=0x100 one cycle after the handshake; INS_DATA shows 0xA..0xD; DAT_DATA_VALID stays 0; IDLE after beat 4.
REQ-033 Tie: INS and DAT both valid from reset, held valid -> grant order INS, DAT, INS, DAT over 4 bursts.
REQ-034 Backpressure: DAT owner drops DAT_DATA_READY for 3 cycles after beat 2 -> L2_DATA_READY 0 for those 3 cycles; still exactly 4 beats delivered; no early IDLE.
REQ-035 L2_ADDR_READY held 0 for 5 cycles -> L2_ADDR_VALID and L2_ADDR stable for all 5 cycles; both ADDR_READY 0.
REQ-036 Reset asserted after beat 2, then 2 more L2 beats after release -> all outputs 0 during reset; FSM IDLE; PROTO_ERR=1; no requester DATA_VALID.
REQ-037 Back-to-back: DAT valid while INS burst ends -> DAT_ADDR_READY 1 exactly the cycle after INS beat 4.

Source files
------------

// File: rtl/l2_read_arbiter.sv
// ---------------------------------------------------------------------------
// l2_read_arbiter
//   Shares one L2 read port between the instruction cache (INS_*) and the
//   data cache (DAT_*). One L2 read is in flight at a time; ties between
//   simultaneous requesters alternate round-robin. The owner's data path is
//   wired straight through to the L2 data channel during the burst.
//
// Ports
//   CLK, RSTN                  clock (rising edge), async active-low reset
//   INS_ADDR/_VALID/_READY     instruction-cache read-address handshake
//   INS_DATA/_VALID/_READY     instruction-cache read-data handshake
//   DAT_ADDR/_VALID/_READY     data-cache read-address handshake
//   DAT_DATA/_VALID/_READY     data-cache read-data handshake
//   L2_ADDR/_VALID/_READY      shared L2 read-address channel
//   L2_DATA/_VALID/_READY      shared L2 read-data channel
//   PROTO_ERR                  sticky: L2 data beat seen outside a burst
// ---------------------------------------------------------------------------
module l2_read_arbiter #(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned W          = 7,
   parameter int unsigned B          = 9
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [ADDR_WIDTH-1:0] INS_ADDR,
   input  logic                  INS_ADDR_VALID,
   output logic                  INS_ADDR_READY,
   output logic [2**W-1:0]       INS_DATA,
   output logic                  INS_DATA_VALID,
   input  logic                  INS_DATA_READY,
   input  logic [ADDR_WIDTH-1:0] DAT_ADDR,
   input  logic                  DAT_ADDR_VALID,
   output logic                  DAT_ADDR_READY,
   output logic [2**W-1:0]       DAT_DATA,
   output logic                  DAT_DATA_VALID,
   input  logic                  DAT_DATA_READY,
   output logic [ADDR_WIDTH-1:0] L2_ADDR,
   output logic                  L2_ADDR_VALID,
   input  logic                  L2_ADDR_READY,
   input  logic [2**W-1:0]       L2_DATA,
   input  logic                  L2_DATA_VALID,
   output logic                  L2_DATA_READY,
   output logic                  PROTO_ERR
);

   localparam int unsigned L2_BURST = 1 << (B - W);
   localparam int unsigned CW       = B - W + 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   typedef enum logic {SRC_INS, SRC_DAT} src_t;

   state_t                state;
   src_t                  last;
   src_t                  owner;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW-1:0]         beats;
   logic                  err_q;

   logic pick_ins, pick_dat, in_idle, route_ins, route_dat, beat;

   always_comb begin
      // A tie goes to whichever side did not win the previous grant.
      pick_ins  = INS_ADDR_VALID && (!DAT_ADDR_VALID || last == SRC_DAT);
      pick_dat  = DAT_ADDR_VALID && (!INS_ADDR_VALID || last == SRC_INS);
      // ADDR_READY is combinational from the inputs, so gate it with reset
      // to keep it low while RSTN is asserted.
      in_idle   = RSTN && state == IDLE;
      route_ins = state == DATA && owner == SRC_INS;
      route_dat = state == DATA && owner == SRC_DAT;

      INS_ADDR_READY = in_idle && pick_ins;
      DAT_ADDR_READY = in_idle && pick_dat;

      L2_ADDR_VALID  = state == ADDR;
      L2_ADDR        = addr_q;

      INS_DATA_VALID = route_ins && L2_DATA_VALID;
      DAT_DATA_VALID = route_dat && L2_DATA_VALID;
      INS_DATA       = route_ins ? L2_DATA : '0;
      DAT_DATA       = route_dat ? L2_DATA : '0;
      L2_DATA_READY  = route_ins ? INS_DATA_READY :
                       route_dat ? DAT_DATA_READY : 1'b0;

      beat      = L2_DATA_VALID && L2_DATA_READY;
      PROTO_ERR = err_q;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state  <= IDLE;
         last   <= SRC_DAT;
         owner  <= SRC_INS;
         addr_q <= '0;
         beats  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (L2_DATA_VALID && state != DATA)
            err_q <= 1'b1;
         case (state)
            IDLE: begin
               if (pick_ins) begin
                  owner  <= SRC_INS;
                  last   <= SRC_INS;
                  addr_q <= INS_ADDR;
                  state  <= ADDR;
               end else if (pick_dat) begin
                  owner  <= SRC_DAT;
                  last   <= SRC_DAT;
                  addr_q <= DAT_ADDR;
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (L2_ADDR_READY)
                  state <= DATA;
            end
            DATA: begin
               if (beat) begin
                  if (beats == CW'(L2_BURST - 1)) begin
                     beats <= '0;
                     state <= IDLE;
                  end else begin
                     beats <= beats + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_read_arbiter.sv
module tb_l2_read_arbiter;

   localparam int AW = 30;
   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic [AW-1:0] INS_ADDR, DAT_ADDR, L2_ADDR;
   logic          INS_ADDR_VALID, INS_ADDR_READY, DAT_ADDR_VALID, DAT_ADDR_READY;
   logic [DW-1:0] INS_DATA, DAT_DATA, L2_DATA;
   logic          INS_DATA_VALID, INS_DATA_READY, DAT_DATA_VALID, DAT_DATA_READY;
   logic          L2_ADDR_VALID, L2_ADDR_READY, L2_DATA_VALID, L2_DATA_READY;
   logic          PROTO_ERR;

   always #5 CLK = ~CLK;

   l2_read_arbiter #(.ADDR_WIDTH(AW), .W(7), .B(9)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .INS_ADDR(INS_ADDR), .INS_ADDR_VALID(INS_ADDR_VALID), .INS_ADDR_READY(INS_ADDR_READY),
      .INS_DATA(INS_DATA), .INS_DATA_VALID(INS_DATA_VALID), .INS_DATA_READY(INS_DATA_READY),
      .DAT_ADDR(DAT_ADDR), .DAT_ADDR_VALID(DAT_ADDR_VALID), .DAT_ADDR_READY(DAT_ADDR_READY),
      .DAT_DATA(DAT_DATA), .DAT_DATA_VALID(DAT_DATA_VALID), .DAT_DATA_READY(DAT_DATA_READY),
      .L2_ADDR(L2_ADDR), .L2_ADDR_VALID(L2_ADDR_VALID), .L2_ADDR_READY(L2_ADDR_READY),
      .L2_DATA(L2_DATA), .L2_DATA_VALID(L2_DATA_VALID), .L2_DATA_READY(L2_DATA_READY),
      .PROTO_ERR(PROTO_ERR)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a request is either waiting for the L2 address
   // channel, or collecting a fixed number of remaining beats, or absent.
   bit            m_wait_addr = 0;
   bit            m_in_burst  = 0;
   bit            m_own_dat   = 0;
   bit            m_last_dat  = 1;
   bit            m_err       = 0;
   int            m_left      = 0;
   logic [AW-1:0] m_addr      = '0;

   bit   idle, g_ins, g_dat, r_ins, r_dat;
   logic e_l2dr;

   int            grant_q[$];
   logic [DW-1:0] ins_q[$];
   logic [DW-1:0] dat_q[$];

   always @(negedge CLK) begin
      if (!RSTN) begin
         chk_bit("rst_ins_addr_ready", INS_ADDR_READY, 1'b0);
         chk_bit("rst_dat_addr_ready", DAT_ADDR_READY, 1'b0);
         chk_bit("rst_ins_data_valid", INS_DATA_VALID, 1'b0);
         chk_bit("rst_dat_data_valid", DAT_DATA_VALID, 1'b0);
         chk_vec("rst_ins_data", INS_DATA, '0);
         chk_vec("rst_dat_data", DAT_DATA, '0);
         chk_vec("rst_l2_addr", DW'(L2_ADDR), '0);
         chk_bit("rst_l2_addr_valid", L2_ADDR_VALID, 1'b0);
         chk_bit("rst_l2_data_ready", L2_DATA_READY, 1'b0);
         chk_bit("rst_proto_err", PROTO_ERR, 1'b0);
         m_wait_addr = 0; m_in_burst = 0; m_own_dat = 0; m_last_dat = 1;
         m_err = 0; m_left = 0; m_addr = '0;
      end else begin
         idle  = !m_wait_addr && !m_in_burst;
         g_ins = idle && INS_ADDR_VALID && (!DAT_ADDR_VALID || m_last_dat);
         g_dat = idle && DAT_ADDR_VALID && (!INS_ADDR_VALID || !m_last_dat);
         r_ins = m_in_burst && !m_own_dat;
         r_dat = m_in_burst && m_own_dat;
         e_l2dr = r_ins ? INS_DATA_READY : (r_dat ? DAT_DATA_READY : 1'b0);

         chk_bit("ins_addr_ready", INS_ADDR_READY, g_ins);
         chk_bit("dat_addr_ready", DAT_ADDR_READY, g_dat);
         chk_bit("l2_addr_valid", L2_ADDR_VALID, m_wait_addr);
         if (m_wait_addr) chk_vec("l2_addr", DW'(L2_ADDR), DW'(m_addr));
         chk_bit("ins_data_valid", INS_DATA_VALID, r_ins && L2_DATA_VALID);
         chk_bit("dat_data_valid", DAT_DATA_VALID, r_dat && L2_DATA_VALID);
         chk_vec("ins_data", INS_DATA, r_ins ? L2_DATA : '0);
         chk_vec("dat_data", DAT_DATA, r_dat ? L2_DATA : '0);
         chk_bit("l2_data_ready", L2_DATA_READY, e_l2dr);
         chk_bit("proto_err", PROTO_ERR, m_err);

         if (INS_ADDR_VALID && INS_ADDR_READY) grant_q.push_back(0);
         if (DAT_ADDR_VALID && DAT_ADDR_READY) grant_q.push_back(1);
         if (INS_DATA_VALID && INS_DATA_READY) ins_q.push_back(INS_DATA);
         if (DAT_DATA_VALID && DAT_DATA_READY) dat_q.push_back(DAT_DATA);

         if (L2_DATA_VALID && !m_in_burst) m_err = 1;
         if (g_ins || g_dat) begin
            m_wait_addr = 1;
            m_own_dat   = g_dat;
            m_last_dat  = g_dat;
            m_addr      = g_dat ? DAT_ADDR : INS_ADDR;
         end else if (m_wait_addr && L2_ADDR_READY) begin
            m_wait_addr = 0;
            m_in_burst  = 1;
            m_left      = 4;
         end else if (m_in_burst && L2_DATA_VALID && e_l2dr) begin
            m_left = m_left - 1;
            if (m_left == 0) m_in_burst = 0;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_logs();
      grant_q.delete();
      ins_q.delete();
      dat_q.delete();
   endtask

   task automatic reset_pulse();
      RSTN = 1'b0;
      tick();
      tick();
      RSTN = 1'b1;
   endtask

   // Acts as the L2 slave for one burst: waits for the address handshake,
   // then offers n beats; optionally drops the owner's DATA_READY for
   // stall_len cycles after beat stall_at.
   task automatic burst(input int n, input logic [DW-1:0] base, input bit stall_dat,
                        input int stall_at, input int stall_len,
                        output int low_cnt, output logic rdy_dat_last);
      bit found = 0;
      bit got;
      low_cnt = 0;
      rdy_dat_last = 1'b0;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (L2_ADDR_VALID && L2_ADDR_READY) begin found = 1; break; end
         tick();
      end
      chk_bit("addr_wait", found, 1'b1);
      if (!found) return;
      tick();
      for (int i = 0; i < n; i++) begin
         L2_DATA_VALID = 1'b1;
         L2_DATA = base + DW'(i);
         got = 0;
         for (int k = 0; k < 50; k++) begin
            #1;
            if (L2_DATA_READY) begin got = 1; break; end
            tick();
         end
         chk_bit("beat_wait", got, 1'b1);
         if (!got) begin L2_DATA_VALID = 1'b0; return; end
         if (i == n - 1) rdy_dat_last = DAT_ADDR_READY;
         tick();
         if (stall_at != 0 && i == stall_at - 1) begin
            if (stall_dat) DAT_DATA_READY = 1'b0; else INS_DATA_READY = 1'b0;
            L2_DATA = base + DW'(i + 1);
            for (int s = 0; s < stall_len; s++) begin
               #1;
               if (!L2_DATA_READY) low_cnt++;
               tick();
            end
            DAT_DATA_READY = 1'b1;
            INS_DATA_READY = 1'b1;
         end
      end
      L2_DATA_VALID = 1'b0;
      L2_DATA = '0;
   endtask

   int   low;
   logic rdy;

   initial begin
      RSTN = 1'b0;
      INS_ADDR = '0; INS_ADDR_VALID = 0; INS_DATA_READY = 0;
      DAT_ADDR = '0; DAT_ADDR_VALID = 0; DAT_DATA_READY = 0;
      L2_ADDR_READY = 0; L2_DATA = '0; L2_DATA_VALID = 0;
      tick(); tick(); tick();
      RSTN = 1'b1;

      // Single INS read
      clear_logs();
      INS_ADDR = 30'h100; INS_ADDR_VALID = 1; INS_DATA_READY = 1; DAT_DATA_READY = 1;
      L2_ADDR_READY = 1;
      #1 chk_bit("t1_ins_addr_ready", INS_ADDR_READY, 1'b1);
      tick();
      INS_ADDR_VALID = 0;
      #1;
      chk_bit("t1_l2_addr_valid", L2_ADDR_VALID, 1'b1);
      chk_vec("t1_l2_addr", DW'(L2_ADDR), DW'(30'h100));
      burst(4, 'hA, 0, 0, 0, low, rdy);
      chk_int("t1_ins_beats", ins_q.size(), 4);
      chk_int("t1_dat_beats", dat_q.size(), 0);
      if (ins_q.size() == 4) begin
         chk_vec("t1_beat0", ins_q[0], 'hA);
         chk_vec("t1_beat3", ins_q[3], 'hD);
      end

      // Tie from reset: INS, DAT, INS, DAT
      RSTN = 1'b0;
      INS_ADDR = 30'h200; DAT_ADDR = 30'h300;
      INS_ADDR_VALID = 1; DAT_ADDR_VALID = 1;
      tick(); tick();
      clear_logs();
      RSTN = 1'b1;
      for (int j = 0; j < 4; j++) burst(4, DW'(16 * (j + 1)), 0, 0, 0, low, rdy);
      INS_ADDR_VALID = 0; DAT_ADDR_VALID = 0;
      chk_int("t2_grants", grant_q.size(), 4);
      if (grant_q.size() >= 4) begin
         chk_int("t2_grant0", grant_q[0], 0);
         chk_int("t2_grant1", grant_q[1], 1);
         chk_int("t2_grant2", grant_q[2], 0);
         chk_int("t2_grant3", grant_q[3], 1);
      end
      chk_int("t2_ins_beats", ins_q.size(), 8);
      chk_int("t2_dat_beats", dat_q.size(), 8);

      // DAT backpressure after beat 2
      reset_pulse();
      clear_logs();
      DAT_ADDR = 30'h40; DAT_ADDR_VALID = 1;
      #1 chk_bit("t3_dat_addr_ready", DAT_ADDR_READY, 1'b1);
      tick();
      DAT_ADDR_VALID = 0;
      burst(4, 'h50, 1, 2, 3, low, rdy);
      chk_int("t3_stall_cycles", low, 3);
      chk_int("t3_dat_beats", dat_q.size(), 4);
      chk_int("t3_ins_beats", ins_q.size(), 0);
      if (dat_q.size() == 4) chk_vec("t3_beat3", dat_q[3], 'h53);

      // L2 address stall, then back-to-back DAT grant
      reset_pulse();
      clear_logs();
      INS_ADDR = 30'h7777; INS_ADDR_VALID = 1; L2_ADDR_READY = 0;
      #1 chk_bit("t4_ins_addr_ready", INS_ADDR_READY, 1'b1);
      tick();
      DAT_ADDR = 30'h88; DAT_ADDR_VALID = 1;
      for (int s = 0; s < 5; s++) begin
         #1;
         chk_bit("t4_l2_addr_valid", L2_ADDR_VALID, 1'b1);
         chk_vec("t4_l2_addr", DW'(L2_ADDR), DW'(30'h7777));
         chk_bit("t4_ins_addr_ready", INS_ADDR_READY, 1'b0);
         chk_bit("t4_dat_addr_ready", DAT_ADDR_READY, 1'b0);
         tick();
      end
      INS_ADDR_VALID = 0;
      L2_ADDR_READY = 1;
      burst(4, 'h60, 0, 0, 0, low, rdy);
      chk_bit("t6_no_grant_on_last_beat", rdy, 1'b0);
      #1 chk_bit("t6_dat_ready_after_beat4", DAT_ADDR_READY, 1'b1);
      tick();
      DAT_ADDR_VALID = 0;
      burst(4, 'h70, 0, 0, 0, low, rdy);
      chk_int("t6_dat_beats", dat_q.size(), 4);
      chk_int("t6_grants", grant_q.size(), 2);

      // Reset mid-burst, then unsolicited beats
      reset_pulse();
      clear_logs();
      INS_ADDR = 30'h500; INS_ADDR_VALID = 1;
      #1 chk_bit("t5_ins_addr_ready", INS_ADDR_READY, 1'b1);
      tick();
      INS_ADDR_VALID = 0;
      burst(2, 'h90, 0, 0, 0, low, rdy);
      RSTN = 1'b0;
      INS_ADDR_VALID = 1; L2_DATA_VALID = 1; L2_DATA = 'hFF;
      #1;
      chk_bit("t5_rst_ins_addr_ready", INS_ADDR_READY, 1'b0);
      chk_bit("t5_rst_l2_data_ready", L2_DATA_READY, 1'b0);
      chk_bit("t5_rst_ins_data_valid", INS_DATA_VALID, 1'b0);
      tick(); tick();
      INS_ADDR_VALID = 0;
      RSTN = 1'b1;
      tick();
      L2_DATA = 'hFE;
      tick();
      L2_DATA_VALID = 0;
      #1;
      chk_bit("t5_proto_err", PROTO_ERR, 1'b1);
      chk_int("t5_ins_beats", ins_q.size(), 2);
      INS_ADDR_VALID = 1;
      #1 chk_bit("t5_idle_after_reset", INS_ADDR_READY, 1'b1);
      tick();
      INS_ADDR_VALID = 0;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
